// File: rtl/fb_pkg.sv
// Shared constants, scan state type and address helper for the plot sink.
// No logic of its own; purely compile-time definitions.
// No backpressure: everything here is combinational or constant.
package fb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int AW = 15;

  localparam logic [XW-1:0] X_LIM  = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIM  = YW'(SCREEN_H);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
  localparam logic [AW-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Row-major linear address; 15 bits holds 19199 so nothing is truncated.
  function automatic logic [AW-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(SCREEN_W) + AW'(x);
  endfunction

endpackage

// File: rtl/fb_plot_sink_if.sv
// Plot strobe bus plus the start/done scanout stream between drawer and sink.
// Latency is defined by the consumer; the interface itself is wires only.
// Plot side has no backpressure; scanout uses a level-held start / done handshake.
interface fb_plot_sink_if;
  import fb_pkg::*;

  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  logic          rd_start;
  logic          rd_done;
  logic          rd_valid;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [CW-1:0] rd_colour;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, rd_start,
    input  rd_done, rd_valid, rd_x, rd_y, rd_colour
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, rd_start,
    output rd_done, rd_valid, rd_x, rd_y, rd_colour
  );

endinterface

// File: rtl/fb_ram.sv
// Framebuffer storage: one write port, one synchronous read port.
// Read data appears one cycle after the address; a same-address write returns old data.
// No backpressure: both ports accept an access every cycle.
module fb_ram
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [FB_DEPTH];

  // Pixel write; contents deliberately have no reset so they survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fb_plot_sink.sv
// Captures in-bounds plots into a 160x120x3 framebuffer and streams it out in raster order.
// Plot write takes effect on the sampling edge; first scan beat appears 2 edges after rd_start is sampled.
// Plots are never stalled; the scan runs to completion once started, rd_done holds until rd_start drops.
module fb_plot_sink
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fb_plot_sink_if.slave bus,
  output logic [AW-1:0] plot_count,
  output logic          oob_err
);

  scan_state_t   state, state_next;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;
  logic          issue;
  logic          last_px;

  logic          issue_vld;
  logic [XW-1:0] issue_x;
  logic [YW-1:0] issue_y;
  logic [CW-1:0] ram_rdata;

  logic          in_bounds;
  logic          wr_en;
  logic          oob_hit;

  assign in_bounds = (bus.vga_x < X_LIM) && (bus.vga_y < Y_LIM);
  assign wr_en     = bus.vga_plot && in_bounds;
  assign oob_hit   = bus.vga_plot && !in_bounds;
  assign last_px   = (scan_x == X_LAST) && (scan_y == Y_LAST);

  fb_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (fb_addr(bus.vga_x, bus.vga_y)),
    .wdata (bus.vga_colour),
    .re    (issue),
    .raddr (fb_addr(scan_x, scan_y)),
    .rdata (ram_rdata)
  );

  // Accepted-plot counter (saturating) and sticky out-of-bounds flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plot_count <= '0;
      oob_err    <= 1'b0;
    end else begin
      if (wr_en && (plot_count != PC_MAX)) begin
        plot_count <= plot_count + 1'b1;
      end
      if (oob_hit) begin
        oob_err <= 1'b1;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scan next-state: one read issued per READ cycle, DONE waits for rd_start to drop.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_start) begin
          state_next = READ;
        end
      end
      READ: begin
        issue = 1'b1;
        if (last_px) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.rd_start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster read pointer: x fastest, parked at (0,0) whenever no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (!issue) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (scan_x == X_LAST) begin
      scan_x <= '0;
      scan_y <= scan_y + 1'b1;
    end else begin
      scan_x <= scan_x + 1'b1;
    end
  end

  // Coordinates travel alongside the RAM read so they line up with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_vld <= 1'b0;
      issue_x   <= '0;
      issue_y   <= '0;
    end else begin
      issue_vld <= issue;
      if (issue) begin
        issue_x <= scan_x;
        issue_y <= scan_y;
      end
    end
  end

  // Output beat register; rd_done rises only once the last beat has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid  <= 1'b0;
      bus.rd_x      <= '0;
      bus.rd_y      <= '0;
      bus.rd_colour <= '0;
      bus.rd_done   <= 1'b0;
    end else begin
      bus.rd_valid <= issue_vld;
      if (issue_vld) begin
        bus.rd_x      <= issue_x;
        bus.rd_y      <= issue_y;
        bus.rd_colour <= ram_rdata;
      end
      bus.rd_done <= (state == DONE) && bus.rd_start && !issue_vld;
    end
  end

endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed bench for fb_plot_sink: reset, plot capture, bounds, scanout timing and handshake.
// Inputs driven and outputs sampled on the falling edge, away from the active edge.
// Scan results are compared against a bench-side framebuffer array.
module tb_fb_plot_sink;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] plot_count;
  logic        oob_err;

  fb_plot_sink_if bus();

  fb_plot_sink dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .plot_count (plot_count),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0] fb_model [19200];

  int         sc_lat;
  int         sc_beats;
  int         sc_data_err;
  int         sc_order_err;
  logic [7:0] sc_last_x;
  logic [6:0] sc_last_y;

  // One plot strobe for one cycle; the model mirrors only in-bounds writes.
  task automatic plot_px(input int x, input int y, input int c);
    bus.vga_x      = 8'(x);
    bus.vga_y      = 7'(y);
    bus.vga_colour = 3'(c);
    bus.vga_plot   = 1'b1;
    if (x < 160 && y < 120) fb_model[y * 160 + x] = 3'(c);
    @(negedge clk);
  endtask

  // Raise rd_start and collect a scan; stop_at=0 runs to the end, else returns after that many beats.
  task automatic run_scan(input int stop_at);
    int ex;
    int ey;
    ex = 0;
    ey = 0;
    sc_lat = 0;
    sc_beats = 0;
    sc_data_err = 0;
    sc_order_err = 0;
    sc_last_x = '0;
    sc_last_y = '0;
    bus.rd_start = 1'b1;
    do begin
      @(negedge clk);
      sc_lat++;
    end while (bus.rd_valid !== 1'b1 && sc_lat < 10);
    sc_lat = sc_lat - 1;
    while (bus.rd_valid === 1'b1 && sc_beats < 19300) begin
      if (bus.rd_x !== 8'(ex) || bus.rd_y !== 7'(ey)) sc_order_err++;
      if (ey >= 120) sc_data_err++;
      else if (bus.rd_colour !== fb_model[ey * 160 + ex]) sc_data_err++;
      sc_last_x = bus.rd_x;
      sc_last_y = bus.rd_y;
      sc_beats++;
      ex++;
      if (ex == 160) begin
        ex = 0;
        ey++;
      end
      if (sc_beats == stop_at) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vga_x = '0;
    bus.vga_y = '0;
    bus.vga_colour = '0;
    bus.vga_plot = 1'b0;
    bus.rd_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b want 0", bus.rd_done); end
    checks++; if (plot_count !== 15'd0) begin errors++; $display("FAIL reset_plot_count: got %0d want 0", plot_count); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL reset_oob_err: got %b want 0", oob_err); end
    plot_px(1, 1, 3);
    plot_px(200, 3, 1);
    bus.vga_plot = 1'b0;
    checks++; if (plot_count !== 15'd1) begin errors++; $display("FAIL pre_reset_count: got %0d want 1", plot_count); end
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL pre_reset_oob: got %b want 1", oob_err); end
    #2 rst = 1'b1;
    #1;
    checks++; if (plot_count !== 15'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", plot_count); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL async_reset_oob: got %b want 0", oob_err); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_done !== 1'b0) begin errors++; $display("FAIL async_reset_rd: got valid=%b done=%b want 0 0", bus.rd_valid, bus.rd_done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_plot();
    plot_px(5, 7, 5);
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        if (!(x == 5 && y == 7)) plot_px(x, y, 0);
      end
    end
    bus.vga_plot = 1'b0;
    checks++; if (plot_count !== 15'd19200) begin errors++; $display("FAIL single_count: got %0d want 19200", plot_count); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL single_oob: got %b want 0", oob_err); end
  endtask

  task automatic test_oob();
    plot_px(160, 0, 7);
    plot_px(0, 120, 7);
    bus.vga_plot = 1'b0;
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b want 1", oob_err); end
    checks++; if (plot_count !== 15'd19200) begin errors++; $display("FAIL oob_count: got %0d want 19200", plot_count); end
    @(negedge clk);
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", oob_err); end
  endtask

  task automatic test_scan_single();
    int held_bad;
    run_scan(0);
    checks++; if (sc_lat !== 2) begin errors++; $display("FAIL scan1_latency: got %0d want 2", sc_lat); end
    checks++; if (sc_beats !== 19200) begin errors++; $display("FAIL scan1_beats: got %0d want 19200", sc_beats); end
    checks++; if (sc_order_err !== 0) begin errors++; $display("FAIL scan1_order: got %0d bad beats want 0", sc_order_err); end
    checks++; if (sc_data_err !== 0) begin errors++; $display("FAIL scan1_data: got %0d bad beats want 0", sc_data_err); end
    checks++; if (sc_last_x !== 8'd159 || sc_last_y !== 7'd119) begin errors++; $display("FAIL scan1_last: got (%0d,%0d) want (159,119)", sc_last_x, sc_last_y); end
    checks++; if (bus.rd_done !== 1'b1) begin errors++; $display("FAIL scan1_done_rise: got %b want 1", bus.rd_done); end
    checks++; if (bus.rd_x !== 8'd159 || bus.rd_y !== 7'd119) begin errors++; $display("FAIL scan1_hold_xy: got (%0d,%0d) want (159,119)", bus.rd_x, bus.rd_y); end
    held_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rd_done !== 1'b1 || bus.rd_valid !== 1'b0) held_bad++;
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL scan1_done_held: got %0d bad cycles want 0", held_bad); end
  endtask

  task automatic test_handshake_reset_mid_scan();
    bus.rd_start = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_done !== 1'b0) begin errors++; $display("FAIL hs_done_drop: got %b want 0", bus.rd_done); end
    run_scan(100);
    checks++; if (sc_lat !== 2) begin errors++; $display("FAIL hs_restart_latency: got %0d want 2", sc_lat); end
    checks++; if (sc_beats !== 100 || sc_data_err !== 0) begin errors++; $display("FAIL hs_restart_data: got beats=%0d bad=%0d want 100 0", sc_beats, sc_data_err); end
    #2 rst = 1'b1;
    bus.rd_start = 1'b0;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midscan_reset_valid: got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_done !== 1'b0) begin errors++; $display("FAIL midscan_reset_done: got %b want 0", bus.rd_done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rescan_identical();
    run_scan(1200);
    checks++; if (sc_lat !== 2) begin errors++; $display("FAIL rescan_latency: got %0d want 2", sc_lat); end
    checks++; if (sc_beats !== 1200 || sc_order_err !== 0) begin errors++; $display("FAIL rescan_order: got beats=%0d bad=%0d want 1200 0", sc_beats, sc_order_err); end
    checks++; if (sc_data_err !== 0) begin errors++; $display("FAIL rescan_data: got %0d bad beats want 0", sc_data_err); end
    #2 rst = 1'b1;
    bus.rd_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_fill();
    int held_bad;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) plot_px(x, y, x % 8);
    end
    bus.vga_plot = 1'b0;
    checks++; if (plot_count !== 15'd19200) begin errors++; $display("FAIL fill_count: got %0d want 19200", plot_count); end
    run_scan(0);
    checks++; if (sc_beats !== 19200) begin errors++; $display("FAIL fill_beats: got %0d want 19200", sc_beats); end
    checks++; if (sc_data_err !== 0 || sc_order_err !== 0) begin errors++; $display("FAIL fill_data: got bad data=%0d order=%0d want 0 0", sc_data_err, sc_order_err); end
    checks++; if (sc_last_x !== 8'd159 || sc_last_y !== 7'd119) begin errors++; $display("FAIL fill_last: got (%0d,%0d) want (159,119)", sc_last_x, sc_last_y); end
    checks++; if (bus.rd_colour !== 3'd7) begin errors++; $display("FAIL fill_hold_colour: got %0d want 7", bus.rd_colour); end
    held_bad = 0;
    repeat (4) begin
      if (bus.rd_done !== 1'b1) held_bad++;
      @(negedge clk);
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL fill_done_held: got %0d bad cycles want 0", held_bad); end
    bus.rd_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_before_write();
    logic [2:0] old_c;
    old_c = fb_model[0];
    bus.rd_start = 1'b1;
    @(negedge clk);
    plot_px(0, 0, 6);
    bus.vga_plot = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_x !== 8'd0 || bus.rd_y !== 7'd0) begin errors++; $display("FAIL rbw_first_beat: got valid=%b (%0d,%0d) want 1 (0,0)", bus.rd_valid, bus.rd_x, bus.rd_y); end
    checks++; if (bus.rd_colour !== old_c) begin errors++; $display("FAIL rbw_old_data: got %0d want %0d", bus.rd_colour, old_c); end
    #2 rst = 1'b1;
    bus.rd_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_scan(1);
    checks++; if (sc_beats !== 1 || bus.rd_colour !== 3'd6) begin errors++; $display("FAIL rbw_new_data: got beats=%0d colour=%0d want 1 6", sc_beats, bus.rd_colour); end
    #2 rst = 1'b1;
    bus.rd_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_oob();
    test_scan_single();
    test_handshake_reset_mid_scan();
    test_rescan_identical();
    test_full_fill();
    test_read_before_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_plot_sink.md
Name: fb_plot_sink

Overview:
- Consumer end of the plot interface driven by fillscreen and the other drawing blocks (vga_x / vga_y / vga_colour / vga_plot).
- Captures every in-bounds plot strobe into an on-chip 160x120x3 framebuffer.
- Counts accepted plots and flags out-of-bounds plots.
- Provides a start/done scanout port that streams the framebuffer in raster order, so benches and a later VGA/compare stage can read back what the drawer produced.

Parameters:
- SCREEN_W, 160, pixels per row
- SCREEN_H, 120, rows
- CW, 3, colour width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- vga_x  input  8  plot column
- vga_y  input  7  plot row
- vga_colour  input  3  plot colour
- vga_plot  input  1  plot strobe, one pixel per high cycle
- rd_start  input  1  scanout request, level-held until rd_done seen
- rd_done  output  1  scanout complete
- rd_valid  output  1  rd_x/rd_y/rd_colour valid this cycle
- rd_x  output  8  scanout column
- rd_y  output  7  scanout row
- rd_colour  output  3  scanout pixel colour
- plot_count  output  15  accepted plots since reset, saturating at 32767
- oob_err  output  1  sticky: an out-of-bounds plot was seen

Behaviour:
- Reset (async, rst=1): scan FSM to IDLE; rd_done, rd_valid, rd_x, rd_y, rd_colour, plot_count and oob_err all 0. Framebuffer contents are not cleared and survive reset.
- Write path:
  - On each edge with vga_plot=1, vga_x<160 and vga_y<120: mem[vga_y*160+vga_x] <= vga_colour and plot_count++ (saturating).
  - Address arithmetic is 15 bits wide, with no truncation.
  - On an edge with vga_plot=1 and vga_x>=160 or vga_y>=120: no write, plot_count unchanged, oob_err <= 1. oob_err holds until reset.
  - The write path is independent of the scan FSM and is accepted in every state.
- Scan FSM states: IDLE, READ, DONE.
  - IDLE: on an edge with rd_start=1, go to READ with the read address at (0,0).
  - READ: issue one read per cycle, row-major with x fastest. After (159,119) has been issued, go to DONE.
  - DONE: rd_done=1 while rd_start=1. The edge with rd_start=0 returns to IDLE and clears rd_done. Deasserting rd_start early during READ is ignored; the scan completes.
- Read timing:
  - The RAM read is synchronous with 1-cycle latency.
  - rd_valid/rd_x/rd_y/rd_colour are registered together, so rd_x/rd_y always describe the pixel carried by rd_colour.
  - The first rd_valid=1 is seen 2 edges after the edge that samples rd_start.
  - Exactly 19200 consecutive rd_valid cycles follow, ending with rd_x=159, rd_y=119.
  - rd_done rises on the same edge that drops rd_valid.
  - rd_x/rd_y/rd_colour hold their last values when rd_valid=0.
- Simultaneous write and read of the same address: the read returns the old data (read-before-write). The new data is visible on the next scan.
- Reset during READ or DONE: FSM returns to IDLE immediately, rd_valid and rd_done go to 0, and no partial-scan state is kept.

Decomposition:
- Package fb_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, FB_DEPTH=19200
  - width constants XW=8, YW=7, CW=3, AW=15
  - typedef enum scan_state_t {IDLE, READ, DONE}
- Sub-module fb_ram: simple dual-port RAM, FB_DEPTH x CW, one synchronous write port, one synchronous-read port with 1-cycle latency and read-before-write. It has no reset.
- fb_plot_sink holds the bounds check, counters, scan FSM and output registers.

Test Plan:
- Reset: assert rst mid-cycle -> rd_done, rd_valid, plot_count and oob_err all 0 asynchronously, before the next clock edge.
- Single plot (5,7,3'b101), then fill the remaining pixels with 3'b000 and scan -> rd_colour=3'b101 exactly when rd_x=5, rd_y=7 (index 1125), 0 elsewhere; plot_count=19200.
- Full fill with colour=x%8 and rd_start held -> 19200 rd_valid cycles, each rd_colour=rd_x%8, last beat rd_x=159 rd_y=119; rd_done=1 on the following cycle and held while rd_start=1.
- Out-of-bounds plots (160,0,3'b111) and (0,120,3'b111) -> oob_err=1, plot_count unchanged; a scan shows (0,0) unchanged.
- Handshake: in DONE drop rd_start -> rd_done=0 after 1 edge; raise rd_start again -> a new scan starts, first rd_valid after 2 edges.
- Reset mid-scan at beat 100 -> rd_valid=0 and rd_done=0 immediately. Then:
  - a rescan returns identical data;
  - writing (0,0) on the cycle it is read returns the old colour, and the next scan returns the new colour.
